// File: rtl/ce_mc_if.sv
// Beat/result bundle of the multi-cycle convolution element.
// The window source drives the master side; ce_mc is the slave.
interface ce_mc_if #(
    parameter int P      = 2,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int B      = 8,
    parameter int OUT_W  = 8
);
    logic [P*KERNEL*KERNEL*N-1:0] data2conv;
    logic [P*KERNEL*KERNEL*M-1:0] w;
    logic                         en_in;
    logic                         clear;
    logic [B-1:0]                 bias;
    logic                         relu_en;
    logic [OUT_W-1:0]             d_out;
    logic                         en_out;
    logic                         busy;

    modport master (
        output data2conv, w, en_in, clear, bias, relu_en,
        input  d_out, en_out, busy
    );

    modport slave (
        input  data2conv, w, en_in, clear, bias, relu_en,
        output d_out, en_out, busy
    );
endinterface

// File: rtl/ce_mc.sv
// Time-multiplexed convolution element: G beats of P channels per window.
// Define CE_ROUND_EN for round-half-up before the output shift.
module ce_mc #(
    parameter int CL_IN  = 4,
    parameter int KERNEL = 3,
    parameter int P      = 2,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int B      = 8,
    parameter int SR     = 2,
    parameter int OUT_W  = 8
) (
    input logic   clk,
    input logic   rst,
    ce_mc_if.slave bus
);
    localparam int G     = CL_IN / P;
    localparam int L     = P * KERNEL * KERNEL;
    localparam int ACC_W = N + M + 1 + $clog2(CL_IN * KERNEL * KERNEL) + 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int SW    = ACC_W + 1;
    localparam int RND   = (SR > 0) ? (1 << ((SR > 0) ? (SR - 1) : 0)) : 0;

    localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [GW-1:0]           grp_cnt_q, grp_cnt_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    res_vld_q, res_vld_d;
    logic                    relu_q, relu_d;
    logic [OUT_W-1:0]        d_out_q, d_out_d;
    logic                    en_out_q, en_out_d;

    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [SW-1:0]    rx;
    logic signed [SW-1:0]    sx;
    logic [OUT_W-1:0]        sat;
    logic                    last;

    // Data lanes are unsigned: zero-extend; weights are sign-extended.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < L; i++) begin
            beat_sum = beat_sum
                + $signed({{(ACC_W-N){1'b0}}, bus.data2conv[i*N +: N]})
                * $signed({{(ACC_W-M){bus.w[i*M+M-1]}}, bus.w[i*M +: M]});
        end
    end

    assign bias_x = {{(ACC_W-B){bus.bias[B-1]}}, bus.bias};
    assign last   = (grp_cnt_q == GW'(G - 1));

    always_comb begin
        rx = {res_q[ACC_W-1], res_q};
`ifdef CE_ROUND_EN
        rx = rx + SW'(RND);
`endif
        sx = rx >>> SR;
        if (relu_q && sx < 0) begin
            sx = '0;
        end
        if (sx > MAXV) begin
            sat = MAXV[OUT_W-1:0];
        end else if (sx < MINV) begin
            sat = MINV[OUT_W-1:0];
        end else begin
            sat = sx[OUT_W-1:0];
        end
    end

    always_comb begin
        acc_d     = acc_q;
        grp_cnt_d = grp_cnt_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        relu_d    = relu_q;
        d_out_d   = d_out_q;
        en_out_d  = 1'b0;
        if (bus.clear) begin
            acc_d     = '0;
            grp_cnt_d = '0;
        end else if (bus.en_in) begin
            if (last) begin
                res_d     = acc_q + beat_sum + bias_x;
                res_vld_d = 1'b1;
                relu_d    = bus.relu_en;
                acc_d     = '0;
                grp_cnt_d = '0;
            end else begin
                acc_d     = acc_q + beat_sum;
                grp_cnt_d = grp_cnt_q + GW'(1);
            end
        end
        // A clear on the output edge kills the pending result.
        if (res_vld_q && !bus.clear) begin
            d_out_d  = sat;
            en_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            grp_cnt_q <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            relu_q    <= 1'b0;
            d_out_q   <= '0;
            en_out_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            grp_cnt_q <= grp_cnt_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            relu_q    <= relu_d;
            d_out_q   <= d_out_d;
            en_out_q  <= en_out_d;
        end
    end

    assign bus.d_out  = d_out_q;
    assign bus.en_out = en_out_q;
    assign bus.busy   = (grp_cnt_q != '0) || res_vld_q;
endmodule

// File: tb/tb_ce_mc.sv
// Self-checking bench for ce_mc: directed plan steps plus random windows
// compared against an integer window-sum model.
module tb_ce_mc;
    localparam int CL_IN  = 4;
    localparam int KERNEL = 3;
    localparam int P      = 2;
    localparam int N      = 4;
    localparam int M      = 4;
    localparam int B      = 8;
    localparam int SR     = 2;
    localparam int OUT_W  = 8;
    localparam int G      = CL_IN / P;
    localparam int L      = P * KERNEL * KERNEL;

    logic clk;
    logic rst;

    ce_mc_if #(.P(P), .KERNEL(KERNEL), .N(N), .M(M), .B(B), .OUT_W(OUT_W)) bus ();

    ce_mc #(
        .CL_IN(CL_IN), .KERNEL(KERNEL), .P(P), .N(N), .M(M),
        .B(B), .SR(SR), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int dv[L];
    int wv[L];
    int m_acc;
    int m_cnt;
    bit out_v;
    int out_d;
    int held;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_out(input int sum, input bit relu);
        int s;
        s = sum;
`ifdef CE_ROUND_EN
        if (SR > 0) s = s + (1 << (SR - 1));
`endif
        s = s >>> SR;
        if (relu && s < 0) s = 0;
        if (s > (1 << (OUT_W - 1)) - 1) s = (1 << (OUT_W - 1)) - 1;
        if (s < -(1 << (OUT_W - 1))) s = -(1 << (OUT_W - 1));
        return s;
    endfunction

    task automatic fill(input int d, input int wt);
        for (int i = 0; i < L; i++) begin
            dv[i] = d;
            wv[i] = wt;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < L; i++) begin
            dv[i] = int'($urandom_range(0, 15));
            wv[i] = int'($urandom_range(0, 15)) - 8;
        end
    endtask

    // One clock: drive inputs, advance the model, check outputs after the edge.
    task automatic tick(input bit en, input bit clr, input int bias_v, input bit relu_v);
        bit got;
        int r;
        int s;
        bit exp_en;
        got = 1'b0;
        r = 0;
        s = 0;
        for (int i = 0; i < L; i++) begin
            bus.data2conv[i*N +: N] = dv[i][N-1:0];
            bus.w[i*M +: M]         = wv[i][M-1:0];
            s = s + dv[i] * wv[i];
        end
        bus.en_in   = en;
        bus.clear   = clr;
        bus.bias    = bias_v[B-1:0];
        bus.relu_en = relu_v;
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
        end else if (en) begin
            m_acc = m_acc + s;
            if (m_cnt == G - 1) begin
                got   = 1'b1;
                r     = ref_out(m_acc + bias_v, relu_v);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        exp_en = out_v && !clr;
        if (exp_en) held = out_d;
        chk("en_out", int'(bus.en_out), int'(exp_en));
        chk("d_out", int'($signed(bus.d_out)), held);
        chk("busy", int'(bus.busy), int'((m_cnt != 0) || got));
        out_v = got;
        out_d = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_acc  = 0;
        m_cnt  = 0;
        out_v  = 1'b0;
        out_d  = 0;
        held   = 0;
        fill(0, 0);
        rst = 1'b0;
        bus.data2conv = '0;
        bus.w         = '0;
        bus.en_in     = 1'b0;
        bus.clear     = 1'b0;
        bus.bias      = '0;
        bus.relu_en   = 1'b0;
        #3;
        chk("rst_d_out", int'(bus.d_out), 0);
        chk("rst_en_out", int'(bus.en_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(posedge clk);
        #4;
        rst = 1'b1;
        idle(1);

        // 1: all ones, two back-to-back beats
        fill(1, 1);
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(3);
        chk("t1_d_out", int'($signed(bus.d_out)), 9);

        // 2: negative weights, with and without ReLU
        fill(1, -1);
        tick(1'b1, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b1);
        idle(2);
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(2);
        chk("t2_d_out", int'($signed(bus.d_out)), -9);

        // 3: saturation at both rails
        fill(15, 7);
        tick(1'b1, 1'b0, 127, 1'b0);
        tick(1'b1, 1'b0, 127, 1'b0);
        idle(2);
        chk("t3_pos", int'($signed(bus.d_out)), 127);
        fill(15, -8);
        tick(1'b1, 1'b0, 127, 1'b0);
        tick(1'b1, 1'b0, 127, 1'b0);
        idle(2);
        chk("t3_neg", int'($signed(bus.d_out)), -128);

        // 4: bias 2, exercises rounding
        fill(1, 1);
        tick(1'b1, 1'b0, 2, 1'b0);
        tick(1'b1, 1'b0, 2, 1'b0);
        idle(2);

        // 5: abort a partial window with clear
        fill(3, 5);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(3);
        tick(1'b1, 1'b1, 0, 1'b0);
        fill(1, 1);
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(2);
        chk("t5_d_out", int'($signed(bus.d_out)), 9);

        // 6: asynchronous reset between beats
        fill(2, 3);
        tick(1'b1, 1'b0, 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_d_out", int'(bus.d_out), 0);
        chk("t6_en_out", int'(bus.en_out), 0);
        chk("t6_busy", int'(bus.busy), 0);
        m_acc = 0;
        m_cnt = 0;
        out_v = 1'b0;
        held  = 0;
        idle(2);
        #4;
        rst = 1'b1;
        fill(1, 1);
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(2);

        // kill a result on its output edge
        fill(1, 1);
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b0, 40, 1'b0);
        tick(1'b0, 1'b1, 0, 1'b0);
        idle(2);

        // random windows, random gaps, occasional clear
        for (int k = 0; k < 200; k++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            fill_rand();
            if (sel == 0) begin
                tick(1'b1, 1'b1, 0, 1'b0);
            end else if (sel < 5) begin
                tick(1'b0, 1'b0, 0, 1'b0);
            end else begin
                tick(1'b1, 1'b0, int'($urandom_range(0, 255)) - 128,
                     1'($urandom_range(0, 1)));
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
